// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: state encodings,
// default dwell width and the terminal select indices.
package decoder_scan_ctrl_pkg;

  localparam int unsigned DefDwellW = 8;

  localparam logic [3:0] LastUp = 4'd15;
  localparam logic [3:0] LastDn = 4'd0;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StScan  = 2'b01,
    StBlank = 2'b10
  } state_e;

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter: counts active cycles of the current select and flags the
// cycle on which the count reaches the latched dwell value.
module scan_dwell_counter #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell_val,
  output logic               match
);

  localparam logic [DWELL_W-1:0] One = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt_q;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + One;
    end
  end

  assign match = (cnt_q == dwell_val);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sequencer driving the active-low enable and select of a 4-to-16 decoder.
// Sweeps all 16 outputs up or down, once or continuously, holding each for
// dwell+1 cycles with a one-cycle blank between selects.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W = DefDwellW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               en_n,
  output logic [3:0]         S,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [3:0]         s_q, s_d;
  logic               dir_q, dir_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               done_d, wrap_d;
  logic               en_n_q, busy_q, done_q, wrap_q;
  logic               cnt_clr, cnt_en, cnt_match;
  logic               last_idx;
  logic [3:0]         s_step;

  // Counter runs only in SCAN and restarts at every SCAN entry or exit.
  assign cnt_en  = (state_q == StScan);
  assign cnt_clr = (state_q != StScan) || cnt_match;

  scan_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .dwell_val (dwell_q),
    .match     (cnt_match)
  );

  assign last_idx = (s_q == (dir_q ? LastDn : LastUp));
  // Mod-16 step also covers the wrap case.
  assign s_step   = dir_q ? (s_q - 4'd1) : (s_q + 4'd1);

  // Next-state, select and pulse logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    dir_d   = dir_q;
    cont_d  = cont_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StScan;
          dir_d   = dir;
          cont_d  = cont;
          dwell_d = dwell;
          s_d     = dir ? LastUp : LastDn;
        end
      end
      StScan: begin
        if (stop) begin
          state_d = StIdle;
        end else if (cnt_match) begin
          if (last_idx && !cont_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StBlank;
            s_d     = s_step;
            wrap_d  = last_idx;
          end
        end
      end
      StBlank: begin
        state_d = stop ? StIdle : StScan;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= 4'd0;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      dwell_q <= '0;
      en_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      dwell_q <= dwell_d;
      en_n_q  <= (state_d != StScan);
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign en_n = en_n_q;
  assign S    = s_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl. Outputs are packed as
// {en_n, S[3:0], busy, done, wrap} and compared against hand-built vectors.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, dir, cont;
  logic [7:0] dwell;
  logic       en_n, busy, done, wrap;
  logic [3:0] S;
  logic [7:0] obs;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(
    .DWELL_W (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .dir   (dir),
    .cont  (cont),
    .dwell (dwell),
    .en_n  (en_n),
    .S     (S),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  assign obs = {en_n, S, busy, done, wrap};

  function automatic logic [7:0] vec(input logic e, input int s, input logic b, input logic d,
                                     input logic w);
    return {e, s[3:0], b, d, w};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until select s is active, bounded.
  task automatic wait_for(input int s, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (en_n == 1'b0 && S == s[3:0]) found = 1'b1;
      else tick();
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; cont = 1'b0; dwell = 8'd0;
    #12;
    check("reset", obs, vec(1, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of SCAN at S=5.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(5, "reach5");
    rst = 1'b1;
    #1;
    check("rst_async", obs, vec(1, 0, 0, 0, 0));
    #1 rst = 1'b0;
    tick(); tick(); tick();
    check("rst_idle", obs, vec(1, 0, 0, 0, 0));

    // Single ascending pass, dwell=2; dwell change and busy start ignored.
    dwell = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 64; c++) begin
      logic [7:0] e;
      if (c < 63) begin
        if (c % 4 < 3) e = vec(0, c / 4, 1, 0, 0);
        else e = vec(1, c / 4 + 1, 1, 0, 0);
      end else if (c == 63) begin
        e = vec(1, 15, 0, 1, 0);
      end else begin
        e = vec(1, 15, 0, 0, 0);
      end
      check($sformatf("pass_up[%0d]", c), obs, e);
      if (c == 10) dwell = 8'd9;
      start = (c == 20);
      tick();
    end

    // Fast pass with back-to-back restart in the done cycle.
    dwell = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 31; c++) begin
      logic [7:0] e;
      if (c == 31) e = vec(1, 15, 0, 1, 0);
      else if (c % 2 == 0) e = vec(0, c / 2, 1, 0, 0);
      else e = vec(1, c / 2 + 1, 1, 0, 0);
      check($sformatf("pass_fast[%0d]", c), obs, e);
      if (c == 31) start = 1'b1;
      if (c < 31) tick();
    end
    tick();
    start = 1'b0;
    check("b2b", obs, vec(0, 0, 1, 0, 0));

    // Stop while S=7 in SCAN, then restart.
    wait_for(7, "reach7");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop", obs, vec(1, 7, 0, 0, 0));
    tick();
    check("stop_hold", obs, vec(1, 7, 0, 0, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart", obs, vec(0, 0, 1, 0, 0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop2", obs, vec(1, 0, 0, 0, 0));

    // start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check("start_stop", obs, vec(1, 0, 0, 0, 0));
    tick();
    check("start_stop2", obs, vec(1, 0, 0, 0, 0));
    start = 1'b0;
    stop  = 1'b0;

    // Continuous descending sweep, dwell=0, through one wrap.
    dir  = 1'b1;
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 35; c++) begin
      logic [7:0] e;
      if (c % 2 == 0) e = vec(0, 15 - c / 2, 1, 0, 0);
      else e = vec(1, 15 - (c + 1) / 2, 1, 0, c == 31);
      check($sformatf("cont_dn[%0d]", c), obs, e);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("cont_stop", obs, vec(1, 13, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Registered sequencer that sits directly upstream of the 4-to-16 decoder and drives its active-low enable `en_n` and 4-bit select `S`. On command it sweeps all 16 decoder outputs, either once or continuously, in ascending or descending order. Each output is held active for a programmable dwell time. A one-cycle blanking gap (enable deasserted) separates consecutive selects so the decoder never glitches between outputs.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `stop`  in  1  abort the sweep; sampled in every state.
- `dir`  in  1  0 = ascending (0→15), 1 = descending (15→0); latched at start.
- `cont`  in  1  0 = single pass, 1 = continuous wrap; latched at start.
- `dwell`  in  DWELL_W  active cycles per select, minus one; latched at start.
- `en_n`  out  1  active-low decoder enable.
- `S`  out  4  decoder select; S[3] is the MSB.
- `busy`  out  1  high in SCAN and BLANK.
- `done`  out  1  one-cycle pulse at the end of a single pass.
- `wrap`  out  1  one-cycle pulse each time a continuous sweep wraps.

## Operation
- FSM states:
  - IDLE: `en_n`=1, `busy`=0.
  - SCAN: `en_n`=0, `busy`=1.
  - BLANK: `en_n`=1, `busy`=1.
- IDLE → SCAN on `start`=1 and `stop`=0.
  - Latch `dir`, `cont` and `dwell`.
  - Load `S` = 0 if ascending, 15 if descending.
  - Clear the dwell counter.
- SCAN: the dwell counter increments each cycle. When it equals the latched dwell value, SCAN exits.
  - Not last index: go to BLANK. `S` steps ±1 (mod 16) on entry to BLANK and is stable before SCAN is re-entered.
  - Last index (15 ascending, 0 descending) with `cont`=0: go to IDLE and pulse `done`. `S` holds its final value.
  - Last index with `cont`=1: go to BLANK, `S` wraps (15→0 or 0→15), pulse `wrap`.
- BLANK → SCAN unconditionally after 1 cycle; the counter clears.
- `stop`=1 in any state: go to IDLE on the next edge with `en_n`=1. No `done` or `wrap` pulse; `S` holds its value.
- `start` while `busy` is ignored. `start` and `stop` asserted together in IDLE: stop wins and the block stays in IDLE.
- Changes to `dir`, `cont` or `dwell` mid-sweep have no effect until the next start.
- `dwell`=0 gives 1 active cycle per select; the maximum value gives 2^DWELL_W active cycles.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `en_n`=1, `S`=0, `busy`=0, `done`=0, `wrap`=0, state=IDLE, counter=0.
- Reset asserted mid-sweep forces these values immediately, without waiting for a clock edge.
- Latency: `start` sampled at edge k → `en_n`=0 and `S`=first index after edge k.
- Each select is active for `dwell`+1 cycles. Each intermediate transition adds 1 blank cycle.
- Single pass length: 16·(`dwell`+1)+15 cycles from the first active cycle. `done` is high for the one cycle immediately after the last active cycle, coincident with `busy` falling.
- `wrap` is high during the BLANK cycle that precedes the wrapped index.
- `stop` sampled at edge k → `en_n`=1 and `busy`=0 after edge k.
- A new `start` is accepted in the same cycle that `done` is high.

## Structure
- Shared header `decoder_scan_defs.vh` holds:
  - state encodings: IDLE=2'b00, SCAN=2'b01, BLANK=2'b10;
  - the default `DWELL_W`;
  - `LAST_UP`=4'd15 and `LAST_DN`=4'd0.
- One sub-module, `scan_dwell_counter`: a DWELL_W-bit counter with synchronous clear, enable, and a terminal-match output against the latched dwell value.
- The FSM and the `S` up/down register stay in the top level.
- Downstream connection: `en_n` drives both enables of the decoder, and `S` drives `S` directly.

## Test plan
- Reset mid-SCAN with `S`=5: all outputs return to reset values asynchronously, before the next clock edge. Release reset with `start` low: the block stays in IDLE.
- `dir`=0, `cont`=0, `dwell`=2: `S` steps 0,1,…,15. Each value shows `en_n`=0 for 3 cycles, with a 1-cycle blank between values. `done` pulses at cycle 63 after the first active cycle, then the block returns to IDLE with `S`=15.
- `dir`=1, `cont`=1, `dwell`=0: `S` steps 15…0, then a blank cycle with `wrap`=1, then `S`=15 again. `done` never asserts. `busy` stays high.
- `stop` asserted while `S`=7 is in SCAN: next cycle `en_n`=1, `busy`=0, `S`=7, no `done` pulse. A following `start` restarts the sweep from 0.
- Change `dwell` from 2 to 9 mid-sweep: the dwell stays at 3 active cycles. Pulse `start` while busy: no effect. `start` and `stop` together in IDLE: the block remains in IDLE.
- Back-to-back runs: re-assert `start` in the `done` cycle. The new sweep's first active cycle follows immediately with `S`=0.
